// File: rtl/uc_atualiza_tiros.sv
// Shot-memory updater: on each request, sweeps every slot once. Each loaded shot
// moves one cell in its direction, or is freed if the move would leave the board.
module uc_atualiza_tiros #(
    parameter int N_TIROS     = 16,
    parameter int LARGURA_POS = 4,
    parameter int MAX_X       = 15,
    parameter int MAX_Y       = 15,
    localparam int AW         = $clog2(N_TIROS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   atualiza_tiros,
    input  logic                   mem_loaded,
    input  logic [LARGURA_POS-1:0] mem_pos_x,
    input  logic [LARGURA_POS-1:0] mem_pos_y,
    input  logic [1:0]             mem_opcode,
    output logic [AW-1:0]          endereco_tiro,
    output logic                   escreve_tiro,
    output logic                   novo_loaded,
    output logic [LARGURA_POS-1:0] novo_pos_x,
    output logic [LARGURA_POS-1:0] novo_pos_y,
    output logic [1:0]             novo_opcode,
    output logic                   tiro_removido,
    output logic                   tiros_atualizados,
    output logic [3:0]             db_estado_atualiza_tiros
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESPERA        = 4'h1,
        ZERA_CONTADOR = 4'h2,
        LE_TIRO       = 4'h3,
        VERIFICA      = 4'h4,
        MOVE_TIRO     = 4'h5,
        REMOVE_TIRO   = 4'h6,
        VERIFICA_FIM  = 4'h7,
        INCREMENTA    = 4'h8,
        SINALIZA      = 4'hA,
        ERRO          = 4'hF
    } estado_t;

    localparam logic [AW-1:0]          ULTIMO = AW'(N_TIROS - 1);
    localparam logic [LARGURA_POS-1:0] LIM_X  = LARGURA_POS'(MAX_X);
    localparam logic [LARGURA_POS-1:0] LIM_Y  = LARGURA_POS'(MAX_Y);

    estado_t                estado_q, estado_d;
    logic [AW-1:0]          endereco_q, endereco_d;
    logic                   loaded_q, loaded_d;
    logic                   fora_q, fora_d;
    logic [LARGURA_POS-1:0] prox_x_q, prox_x_d;
    logic [LARGURA_POS-1:0] prox_y_q, prox_y_d;
    logic [1:0]             opcode_q, opcode_d;
    logic                   escreve_q, escreve_d;
    logic                   novo_loaded_q, novo_loaded_d;
    logic [LARGURA_POS-1:0] novo_x_q, novo_x_d;
    logic [LARGURA_POS-1:0] novo_y_q, novo_y_d;
    logic [1:0]             novo_op_q, novo_op_d;
    logic                   removido_q, removido_d;
    logic                   atualizados_q, atualizados_d;

    // Next-position and out-of-bounds evaluation of the slot currently addressed.
    logic [LARGURA_POS-1:0] calc_x, calc_y;
    logic                   calc_fora;

    always_comb begin
        calc_x    = mem_pos_x;
        calc_y    = mem_pos_y;
        calc_fora = 1'b0;
        case (mem_opcode)
            2'b00: if (mem_pos_y == '0)    calc_fora = 1'b1; else calc_y = mem_pos_y - 1'b1;
            2'b01: if (mem_pos_y == LIM_Y) calc_fora = 1'b1; else calc_y = mem_pos_y + 1'b1;
            2'b10: if (mem_pos_x == '0)    calc_fora = 1'b1; else calc_x = mem_pos_x - 1'b1;
            default: if (mem_pos_x == LIM_X) calc_fora = 1'b1; else calc_x = mem_pos_x + 1'b1;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        loaded_d   = loaded_q;
        fora_d     = fora_q;
        prox_x_d   = prox_x_q;
        prox_y_d   = prox_y_q;
        opcode_d   = opcode_q;
        case (estado_q)
            INICIAL:       estado_d = ESPERA;
            ESPERA:        if (atualiza_tiros) estado_d = ZERA_CONTADOR;
            ZERA_CONTADOR: begin
                endereco_d = '0;
                estado_d   = LE_TIRO;
            end
            LE_TIRO: begin
                loaded_d = mem_loaded;
                fora_d   = calc_fora;
                prox_x_d = calc_x;
                prox_y_d = calc_y;
                opcode_d = mem_opcode;
                estado_d = VERIFICA;
            end
            VERIFICA: begin
                if (!loaded_q)   estado_d = VERIFICA_FIM;
                else if (fora_q) estado_d = REMOVE_TIRO;
                else             estado_d = MOVE_TIRO;
            end
            MOVE_TIRO:     estado_d = VERIFICA_FIM;
            REMOVE_TIRO:   estado_d = VERIFICA_FIM;
            VERIFICA_FIM:  estado_d = (endereco_q == ULTIMO) ? SINALIZA : INCREMENTA;
            INCREMENTA: begin
                endereco_d = endereco_q + 1'b1;
                estado_d   = LE_TIRO;
            end
            SINALIZA:      estado_d = ESPERA;
            ERRO:          estado_d = INICIAL;
            default:       estado_d = ERRO;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        escreve_d     = (estado_d == MOVE_TIRO) || (estado_d == REMOVE_TIRO);
        novo_loaded_d = (estado_d == MOVE_TIRO);
        novo_x_d      = (estado_d == MOVE_TIRO) ? prox_x_q : '0;
        novo_y_d      = (estado_d == MOVE_TIRO) ? prox_y_q : '0;
        novo_op_d     = (estado_d == MOVE_TIRO) ? opcode_q : 2'b00;
        removido_d    = (estado_d == REMOVE_TIRO);
        atualizados_d = (estado_d == SINALIZA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= INICIAL;
            endereco_q    <= '0;
            loaded_q      <= 1'b0;
            fora_q        <= 1'b0;
            prox_x_q      <= '0;
            prox_y_q      <= '0;
            opcode_q      <= 2'b00;
            escreve_q     <= 1'b0;
            novo_loaded_q <= 1'b0;
            novo_x_q      <= '0;
            novo_y_q      <= '0;
            novo_op_q     <= 2'b00;
            removido_q    <= 1'b0;
            atualizados_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            endereco_q    <= endereco_d;
            loaded_q      <= loaded_d;
            fora_q        <= fora_d;
            prox_x_q      <= prox_x_d;
            prox_y_q      <= prox_y_d;
            opcode_q      <= opcode_d;
            escreve_q     <= escreve_d;
            novo_loaded_q <= novo_loaded_d;
            novo_x_q      <= novo_x_d;
            novo_y_q      <= novo_y_d;
            novo_op_q     <= novo_op_d;
            removido_q    <= removido_d;
            atualizados_q <= atualizados_d;
        end
    end

    assign endereco_tiro            = endereco_q;
    assign escreve_tiro             = escreve_q;
    assign novo_loaded              = novo_loaded_q;
    assign novo_pos_x               = novo_x_q;
    assign novo_pos_y               = novo_y_q;
    assign novo_opcode              = novo_op_q;
    assign tiro_removido            = removido_q;
    assign tiros_atualizados        = atualizados_q;
    assign db_estado_atualiza_tiros = estado_q;

endmodule
